// File: rtl/xmtr.sv
// rtl/xmtr.sv - serial framing transmitter: MATCH header then payload, MSB first
//
// Sends each accepted byte as a 16-bit frame on data_out: the 8-bit MATCH
// header followed by the 8-bit payload, most significant bit first. The idle
// line is held at 0 so a receiver hunting for MATCH never sees a false header.
//
// Optional feature macro: XMTR_GAP_EN
//   defined   - GAP forced idle cycles (data_out=0, busy=0) follow every frame
//   undefined - frames run back-to-back with no idle cycle in between
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-low reset
//   data_in  in   [7:0] payload byte, captured on an accepted write
//   writing  in   write strobe, accepted only while ready==1
//   ready    out  holding buffer empty
//   busy     out  frame in progress (header or payload bits on the line)
//   overrun  out  sticky: a write was dropped because the buffer was full;
//                 cleared by the next accepted write
//   data_out out  serial line, 0 when idle

module xmtr #(
    parameter logic [7:0] MATCH = 8'hA5
`ifdef XMTR_GAP_EN
    ,
    parameter int unsigned GAP = 1
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       writing,
    output logic       ready,
    output logic       busy,
    output logic       overrun,
    output logic       data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY
`ifdef XMTR_GAP_EN
        ,
        S_GAP
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  shift_q, shift_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        data_out_q, data_out_d;
`ifdef XMTR_GAP_EN
    logic [3:0]  gap_q, gap_d;
`endif

    // Writes are judged on the registered ready, so a write landing on the
    // same edge the buffer drains into the shifter is still rejected.
    logic wr_accept;
    logic wr_reject;
    logic launch;

    assign wr_accept = writing & ready_q;
    assign wr_reject = writing & ~ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hold_d     = hold_q;
        shift_d    = shift_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        data_out_d = data_out_q;
`ifdef XMTR_GAP_EN
        gap_d      = gap_q;
`endif
        launch     = 1'b0;

        if (wr_accept) begin
            hold_d    = data_in;
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end else if (wr_reject) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                count_d    = 3'd0;
                data_out_d = 1'b0;
                busy_d     = 1'b0;
                launch     = ~ready_q;
            end

            S_HEAD: begin
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    state_d    = S_BODY;
                    data_out_d = shift_q[7];
                end else begin
                    // Bit MATCH[7] already went out on the launch edge.
                    data_out_d = MATCH[3'd6 - count_q];
                end
            end

            S_BODY: begin
                count_d = count_q + 3'd1;
                if (count_q != 3'd7) begin
                    data_out_d = shift_q[3'd6 - count_q];
                end else begin
                    data_out_d = 1'b0;
                    busy_d     = 1'b0;
`ifdef XMTR_GAP_EN
                    state_d    = S_GAP;
                    gap_d      = 4'(GAP - 1);
`else
                    // A byte written during this frame starts the next one
                    // with no idle bit in between.
                    state_d    = S_IDLE;
                    launch     = ~ready_q;
`endif
                end
            end

`ifdef XMTR_GAP_EN
            S_GAP: begin
                count_d    = 3'd0;
                data_out_d = 1'b0;
                busy_d     = 1'b0;
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                    launch  = ~ready_q;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
`endif

            default: begin
                state_d    = S_IDLE;
                count_d    = 3'd0;
                data_out_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // Frame start: the held byte moves to the shifter and the first
        // header bit goes on the line at this same edge.
        if (launch) begin
            state_d    = S_HEAD;
            count_d    = 3'd0;
            shift_d    = hold_q;
            ready_d    = 1'b1;
            busy_d     = 1'b1;
            data_out_d = MATCH[7];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= 3'd0;
            hold_q     <= 8'd0;
            shift_q    <= 8'd0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            data_out_q <= 1'b0;
`ifdef XMTR_GAP_EN
            gap_q      <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
`ifdef XMTR_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign data_out = data_out_q;

endmodule
